keycode_sequencer: RTL and testbench

- Drives the game keycode bus, the same 8-bit bus that tank selection and other key consumers read.
- In attract/demo mode it replays a programmable script of timed key presses.
- After each press it inserts key-release gaps, so edge-detecting consumers see each press as a distinct event.
- When idle it passes the live keyboard keycode through unchanged.

---
 rtl/keyseq_pkg.sv | 28 ++
 rtl/keyseq_table.sv | 28 ++
 rtl/keycode_sequencer.sv | 143 ++++++++++++++
 tb/tb_keycode_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyseq_pkg.sv
// keyseq_pkg: shared FSM states, script entry layout and common keycodes for the keycode sequencer.
package keyseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        GAP,
        DONE
    } state_e;

    localparam int ENTRY_HOLD_W = 8;

    typedef struct packed {
        logic [7:0]              keycode;
        logic [ENTRY_HOLD_W-1:0] hold;
    } entry_t;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_Q    = 8'h14;
    localparam logic [7:0] KEY_E    = 8'h08;

    // An all-zero entry terminates the script; a zero key with a hold is a timed wait.
    function automatic logic is_end(input logic [7:0] key, input logic any_hold);
        return key == KEY_NONE && !any_hold;
    endfunction

endpackage

// File: rtl/keyseq_table.sv
// keyseq_table: script register file, cleared on reset, one synchronous write port and one combinational read port.
module keyseq_table #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem_q [DEPTH];

    // Reset clears every entry to the end marker; writes land on the next edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/keycode_sequencer.sv
// keycode_sequencer: replays a timed keycode script onto the game key bus, else passes live keys through; define KEYSEQ_LOOP_EN to loop the script.
module keycode_sequencer
    import keyseq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int HOLD_W     = 8,
    parameter int GAP_FRAMES = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic [7:0]               live_keycode,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [8+HOLD_W-1:0]      wr_data,
    output logic [7:0]               keycode_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] entry_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_FRAMES + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        key_q, key_d;
    logic [7:0]        kc_q, kc_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [8+HOLD_W-1:0] rd_data;
    logic [7:0]        rd_key;
    logic [HOLD_W-1:0] rd_hold;
    logic              stop;
    logic              last_idx;

    assign rd_key      = rd_data[8+HOLD_W-1:HOLD_W];
    assign rd_hold     = rd_data[HOLD_W-1:0];
    assign busy        = state_q inside {LOAD, HOLD, GAP};
    assign done        = state_q == DONE;
    assign keycode_out = kc_q;
    assign entry_idx   = idx_q;
    assign last_idx    = idx_q == AW'(DEPTH - 1);
    // A player touching the keyboard during playback stops it just like abort.
    assign stop        = busy && (abort || live_keycode != KEY_NONE);

    keyseq_table #(
        .DEPTH(DEPTH),
        .W    (8 + HOLD_W)
    ) u_table (
        .Clk    (Clk),
        .Reset  (Reset),
        .wr_en  (wr_en && !busy),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(idx_q),
        .rd_data(rd_data)
    );

    // Next-state, counters and the keycode to present on the following cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        kc_d    = KEY_NONE;
        case (state_q)
            IDLE: begin
                kc_d = live_keycode;
                if (start && !abort) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (is_end(rd_key, |rd_hold)) begin
`ifdef KEYSEQ_LOOP_EN
                    state_d = idx_q == '0 ? DONE : LOAD;
                    idx_d   = '0;
`else
                    state_d = DONE;
`endif
                end else begin
                    key_d   = rd_key;
                    hold_d  = rd_hold == '0 ? HOLD_W'(1) : rd_hold;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                kc_d = key_q;
                if (frame_tick) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_FRAMES);
                    end
                end
            end
            GAP: begin
                if (frame_tick) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GW'(1)) begin
`ifdef KEYSEQ_LOOP_EN
                        state_d = LOAD;
                        idx_d   = last_idx ? '0 : idx_q + 1'b1;
`else
                        state_d = last_idx ? DONE : LOAD;
                        idx_d   = last_idx ? idx_q : idx_q + 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            kc_d    = KEY_NONE;
        end
    end

    // State, counters and the registered keycode output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            key_q   <= KEY_NONE;
            kc_q    <= KEY_NONE;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            kc_q    <= kc_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_keycode_sequencer.sv
// tb_keycode_sequencer: directed and randomized script playback against a frame-level reference model.
module tb_keycode_sequencer;
    import keyseq_pkg::*;

    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, start, abort, wr_en, busy, done;
    logic [7:0] live_keycode, keycode_out;
    logic [3:0] wr_addr, entry_idx;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int nz_cnt = 0;
    int rise_cnt = 0;
    logic [7:0] prev_kc = 8'h00;

    logic [7:0] scr_k [DEPTH];
    int         scr_h [DEPTH];

    keycode_sequencer #(.DEPTH(DEPTH), .HOLD_W(8), .GAP_FRAMES(GAP)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .live_keycode(live_keycode),
        .start       (start),
        .abort       (abort),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .keycode_out (keycode_out),
        .busy        (busy),
        .done        (done),
        .entry_idx   (entry_idx)
    );

    always #5 Clk = ~Clk;

    // Event counters for done pulses, non-zero keycode cycles and distinct Q presses.
    always @(negedge Clk) begin
        if (done) done_cnt++;
        if (keycode_out != 8'h00) nz_cnt++;
        if (keycode_out == KEY_Q && prev_kc != KEY_Q) rise_cnt++;
        prev_kc = keycode_out;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] k, input int h);
        entry_t e;
        e.keycode = k;
        e.hold    = h[7:0];
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = e;
        step();
        wr_en = 1'b0;
        scr_k[a] = k;
        scr_h[a] = h;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            scr_k[i] = 8'h00;
            scr_h[i] = 0;
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] ek, input int ei);
        repeat (5) step();
        chk({tag, " kc"}, keycode_out, ek);
        chk({tag, " idx"}, entry_idx, ei);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (4) step();
    endtask

    task automatic run_script(input string name, input bit do_wr, input int a, input logic [7:0] k, input int h);
        logic [7:0] ek [$];
        int ei [$];
        int n, d0, last;
        entry_t e;
        if (do_wr) begin
            e.keycode = k;
            e.hold    = h[7:0];
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_data = e;
            scr_k[a] = k;
            scr_h[a] = h;
        end
        last = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (scr_k[i] == 8'h00 && scr_h[i] == 0) begin
                last = i;
                break;
            end
            n = scr_h[i] == 0 ? 1 : scr_h[i];
            repeat (n) begin ek.push_back(scr_k[i]); ei.push_back(i); end
            repeat (GAP) begin ek.push_back(8'h00); ei.push_back(i); end
        end
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        chk({name, " busy"}, busy, 1);
        foreach (ek[j]) frame($sformatf("%s f%0d", name, j), ek[j], ei[j]);
        repeat (3) step();
        chk({name, " done pulses"}, done_cnt - d0, 1);
        chk({name, " busy end"}, busy, 0);
        chk({name, " idx end"}, entry_idx, last);
        chk({name, " kc end"}, keycode_out, 0);
    endtask

    initial begin
        int d0, r0, nz0, nent;
        logic [7:0] rk;
        Reset = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        live_keycode = 8'h00;
        clear_model();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset kc", keycode_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset idx", entry_idx, 0);
        Reset = 1'b0;
        step();

        live_keycode = 8'h33;
        chk("pass before edge", keycode_out, 0);
        step();
        chk("pass after edge", keycode_out, 8'h33);
        live_keycode = 8'h00;
        step();

        wr(0, KEY_Q, 3);
        wr(1, KEY_E, 2);
        wr(2, 8'h00, 0);
        run_script("basic", 0, 0, 0, 0);

        wr(0, KEY_Q, 1);
        wr(1, KEY_Q, 1);
        wr(2, 8'h00, 0);
        r0 = rise_cnt;
        run_script("b2b", 0, 0, 0, 0);
        chk("b2b presses", rise_cnt - r0, 2);

        wr(0, KEY_Q, 5);
        wr(1, 8'h00, 0);
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        frame("tko f0", KEY_Q, 0);
        frame("tko f1", KEY_Q, 0);
        live_keycode = 8'h1A;
        step();
        chk("tko busy", busy, 0);
        chk("tko kc", keycode_out, 0);
        step();
        chk("tko pass", keycode_out, 8'h1A);
        live_keycode = 8'h00;
        repeat (10) step();
        chk("tko no done", done_cnt - d0, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        frame("abt f0", KEY_Q, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt busy", busy, 0);
        chk("abt kc", keycode_out, 0);
        repeat (10) step();
        chk("abt no done", done_cnt - d0, 0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", busy, 0);
        step();
        chk("start+abort busy2", busy, 0);

        wr(0, KEY_Q, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = {KEY_E, 8'd5};
        step();
        wr_en = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        run_script("busy write", 0, 0, 0, 0);

        wr(0, KEY_E, 0);
        run_script("hold0", 0, 0, 0, 0);

        wr(1, 8'h00, 0);
        run_script("wr+start", 1, 0, KEY_E, 2);

        for (int i = 0; i < DEPTH; i++) wr(i, 8'h04, 1);
        run_script("full", 0, 0, 0, 0);

        for (int t = 0; t < 4; t++) begin
            nent = $urandom_range(1, 5);
            for (int i = 0; i < DEPTH; i++) begin
                if (i < nent) begin
                    case ($urandom_range(0, 3))
                        0: rk = 8'h00;
                        1: rk = KEY_Q;
                        2: rk = KEY_E;
                        default: rk = 8'($urandom_range(1, 255));
                    endcase
                    wr(i, rk, $urandom_range(0, 3));
                end else begin
                    wr(i, 8'h00, 0);
                end
            end
            run_script($sformatf("rand%0d", t), 0, 0, 0, 0);
        end

        wr(0, KEY_Q, 4);
        wr(1, 8'h00, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        frame("rst f0", KEY_Q, 0);
        #2 Reset = 1'b1;
        #1;
        chk("rst kc", keycode_out, 0);
        chk("rst busy", busy, 0);
        chk("rst idx", entry_idx, 0);
        step();
        Reset = 1'b0;
        step();
        clear_model();
        nz0 = nz_cnt;
        run_script("post-reset", 0, 0, 0, 0);
        chk("post-reset no key", nz_cnt - nz0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
